data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU data-memory port. It accepts one read or write request per cycle on the same request signals the core drives: address, write data, read enable and write strobe. Reads complete with a fixed, parameterised pipelined latency and are signalled by a valid strobe. It replaces the single-cycle data memory so that the pipelined core and a later cache-fill engine can be exercised against realistic multi-cycle memory.

## Interface
- `DWIDTH`, 16: data word width in bits.
- `AWIDTH`, 16: byte-address width in bits.
- `MEM_WORDS`, 1024: number of words in the array. Must be a power of two.
- `LATENCY`, 4: read latency in cycles. Legal range 1..8.

- `clk`  input  1  the only clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `addr`  input  AWIDTH  byte address of the request.
- `data_in`  input  DWIDTH  write data.
- `enable`  input  1  read request.
- `wr`  input  1  write request.
- `data_out`  output  DWIDTH  read data. Valid only while `data_valid` is 1, otherwise 0.
- `data_valid`  output  1  one-cycle strobe per completed read.
- `busy`  output  1  1 while any read is in flight or being presented on the output.

## Operation
- **Word index**
  - Word index = `addr[log2(MEM_WORDS):1]`.
  - `addr[0]` is ignored.
  - Address bits above the index are ignored, so the address wraps modulo `MEM_WORDS` words.
- **Request decode** (sampled every rising edge while `rst`=0)
  - `wr`=1 is a write: `mem[index] <= data_in` at that edge. There is no response. `enable` is don't-care.
  - `enable`=1 with `wr`=0 is a read: `mem[index]` is sampled at that edge and enters the pipeline.
  - `enable`=0 with `wr`=0 is idle.
- **Read pipeline**
  - LATENCY-stage shift register of {valid, data}.
  - The stage-0 capture happens at the request edge. The data reflects every write accepted at earlier edges.
  - Stage LATENCY-1 drives `data_out` and `data_valid`.
  - Requests are never stalled or dropped; one request is accepted per cycle.
  - Responses return in request order.
- **Ordering**
  - A write then a read to the same word on the next edge returns the new data.
  - A read then a write to the same word on the next edge returns the old data.
- **`busy`** is the OR of all pipeline valid bits.
- **Reset**
  - Clears every pipeline valid bit and data stage to 0: `data_out`=0, `data_valid`=0, `busy`=0.
  - Array contents are not cleared; they are retained through reset.
  - Any request presented while `rst`=1 is ignored. A write is not committed.
  - Reads in flight when `rst` is asserted are discarded. No `data_valid` follows for them after reset deasserts.
- Out-of-range `LATENCY` is a configuration error. The RTL must flag it with an elaboration-time check.

## Timing
- A request presented in cycle 0 is sampled at the end of cycle 0.
- A read produces `data_valid`=1 and `data_out`=data during cycle LATENCY only. Both return to 0 in cycle LATENCY+1 unless another read follows.
- Back-to-back reads in cycles 0..N-1 produce valid strobes in cycles LATENCY..LATENCY+N-1, with no bubbles.
- A write is visible to a read sampled at the next edge. Write-to-read turnaround is 1 cycle.
- `busy` rises in cycle 1 after a read is accepted and falls in the cycle after the last `data_valid`.
- `rst` takes effect at the edge where it is sampled: outputs are 0 from the next cycle.
- The array write port is single-cycle and registered.
- `data_out` is driven from the last pipeline register, so there is no combinational path from any input to any output.

## Test plan
- **Reset state:** hold `rst`=1 for 2 cycles → `data_out`=0, `data_valid`=0, `busy`=0; a write presented with `data_in`=0xBEEF during reset is not committed (read back is not 0xBEEF).
- **Write then read:** write 0x1234 to addr 0x0010, then read 0x0010 on the next cycle → `data_valid` pulses exactly 4 cycles after the read with `data_out`=0x1234; `data_valid`=0 in every other cycle.
- **Streaming:** write 0x0A00+i to addr 2*i for i=0..7, then issue 8 consecutive reads → 8 consecutive valid cycles returning 0x0A00..0x0A07 in order; `busy`=1 throughout.
- **Hazard ordering:** mem[0x20]=0x1111; read 0x20, then on the next cycle write 0x2222 to 0x20, then read 0x20 → the two responses are 0x1111 then 0x2222.
- **Aliasing:** write 0x5555 to 0x0006, then read 0x0007 and 0x0806 (`MEM_WORDS`=1024) → both return 0x5555.
- **Mid-flight reset:** issue 3 reads, assert `rst` for 1 cycle two cycles later → no `data_valid` for those reads ever; array contents are unchanged afterwards; a new read after reset returns correct data at latency 4.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data-memory port. Writes commit in one
//   cycle. Reads return through a fixed-latency pipeline, and each completed
//   read raises a one-cycle valid strobe. One request is accepted per cycle.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset (clears the pipeline, not the array)
//   addr       : byte address; word index = addr[log2(MEM_WORDS):1]
//   data_in    : write data
//   enable     : read request (ignored when wr=1)
//   wr         : write request
//   data_out   : read data, 0 whenever data_valid=0
//   data_valid : one-cycle strobe per completed read
//   busy       : 1 while any read is in flight or on the output
module data_mem_responder #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              enable,
    input  logic              wr,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Configuration checks, evaluated at elaboration.
    generate
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be in 1..8");
        end
        if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
            $error("data_mem_responder: MEM_WORDS must be a power of two >= 2");
        end
        if (AWIDTH < IDX_W + 2) begin : g_bad_awidth
            $error("data_mem_responder: AWIDTH too narrow for MEM_WORDS");
        end
    endgenerate

    logic [IDX_W-1:0] idx;
    logic             rd;
    logic             unused_addr;

    // Byte address -> word index. Bit 0 and the bits above the index are
    // dropped, so the address wraps modulo MEM_WORDS words.
    assign idx         = addr[IDX_W:1];
    assign unused_addr = ^{addr[AWIDTH-1:IDX_W+1], addr[0]};
    assign rd          = enable & ~wr;

    // The array is never reset. Its contents survive rst.
    logic [DWIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem[idx] <= data_in;
        end
    end

    // Read pipeline. Stage 0 captures the array at the request edge, so it
    // sees every write committed at earlier edges. A write at the following
    // edge cannot affect data already captured. Idle slots carry zero data,
    // so the last stage can drive data_out directly with no output mux.
    logic [LATENCY-1:0] vld_pipe;
    logic [DWIDTH-1:0]  dat_pipe [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd;
            dat_pipe[0] <= rd ? mem[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign data_out   = dat_pipe[LATENCY-1];
    assign data_valid = vld_pipe[LATENCY-1];
    assign busy       = |vld_pipe;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives directed and random traffic into data_mem_responder. The reference
//   is a word array and a queue of expected responses, each tagged with the
//   cycle in which it must appear. Every cycle, the bench checks
//   data_valid/data_out/busy against that reference.
module tb_data_mem_responder;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int MW  = 1024;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic          enable = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;

    data_mem_responder #(.DWIDTH(DW), .AWIDTH(AW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .enable(enable), .wr(wr), .data_out(data_out),
        .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    logic [15:0] ref_mem [MW];
    rsp_t        pend [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rsp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle. Present the request, let the edge sample it, update the
    // reference, then check the outputs of the following cycle mid-period.
    task automatic step(input logic r, input logic w, input logic en,
                        input int a, input int d);
        int   wi;
        logic exp_v;
        logic exp_b;
        rsp_t h;
        rst = r; wr = w; enable = en; addr = a[AW-1:0]; data_in = d[DW-1:0];
        @(posedge clk);
        wi = (a / 2) % MW;
        if (r) pend.delete();
        else if (w) ref_mem[wi] = d[15:0];
        else if (en) pend.push_back('{due: cyc + 1 + LAT - 1, data: ref_mem[wi]});
        cyc++;
        @(negedge clk);
        exp_b = (pend.size() != 0);
        exp_v = exp_b && (pend[0].due == cyc);
        chk("data_valid", {31'b0, data_valid}, {31'b0, exp_v});
        chk("busy", {31'b0, busy}, {31'b0, exp_b});
        if (exp_v) begin
            h = pend.pop_front();
            n_rsp++;
            chk("data_out", {16'b0, data_out}, {16'b0, h.data});
        end else begin
            chk("data_out_idle", {16'b0, data_out}, 32'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int rsp_before;

        // Reset: hold for two cycles with a write present, which must not land.
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
        chk("rst_data_out", {16'b0, data_out}, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        // Fill the whole array so every later read has a known reference.
        for (int i = 0; i < MW; i++) step(1'b0, 1'b1, 1'b0, 2 * i, $urandom_range(0, 16'hFFFF));

        // Write 0x7777 to a word, then write 0xBEEF to it while rst is held.
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h7777);
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
        step(1'b0, 1'b0, 1'b1, 16'h0040, 0);
        idle(LAT + 1);

        // Write then read: the new data comes back after exactly LAT cycles.
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 16'h0010, 0);
        idle(LAT + 2);

        // Streaming: eight writes, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 2 * i, 16'h0A00 + i);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 2 * i, 0);
        idle(LAT + 1);

        // Hazards: a read before the write returns the old data; a read after it
        // returns the new data.
        step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111);
        step(1'b0, 1'b0, 1'b1, 16'h0020, 0);
        step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
        step(1'b0, 1'b0, 1'b1, 16'h0020, 0);
        idle(LAT + 1);

        // Aliasing: addr[0] is ignored, and addresses wrap at MW words.
        step(1'b0, 1'b1, 1'b0, 16'h0006, 16'h5555);
        step(1'b0, 1'b0, 1'b1, 16'h0007, 0);
        step(1'b0, 1'b0, 1'b1, 16'h0806, 0);
        idle(LAT + 1);

        // Mid-flight reset: three reads are issued, and reset arrives before any
        // of them completes. None of those reads may produce a strobe.
        rsp_before = n_rsp;
        step(1'b0, 1'b0, 1'b1, 16'h0000, 0);
        step(1'b0, 1'b0, 1'b1, 16'h0002, 0);
        step(1'b0, 1'b0, 1'b1, 16'h0004, 0);
        step(1'b1, 1'b0, 1'b1, 16'h0006, 0);
        idle(LAT + 3);
        chk("midrst_no_rsp", n_rsp, rsp_before);
        step(1'b0, 1'b0, 1'b1, 16'h0002, 0);
        idle(LAT + 1);
        chk("midrst_one_rsp", n_rsp, rsp_before + 1);

        // Random traffic, with an occasional reset.
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = $urandom_range(0, 99);
            step(k == 0, (k >= 1) && (k < 35), (k >= 20),
                 $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
        end
        idle(LAT + 2);
        chk("drain_busy", {31'b0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
